// File: rtl/uart_tx_pkg.sv
// Shared types and mux-select encoding for the UART transmit path.
// The select encoding is what the downstream TX output mux decodes.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_DATA  = 2'b01;
  localparam logic [1:0] SEL_PAR   = 2'b10;
  localparam logic [1:0] SEL_IDLE  = 2'b11;

  // STOP shares the idle select because both put a 1 on the line.
  function automatic logic [1:0] sel_of(input tx_state_e s);
    case (s)
      START:   return SEL_START;
      DATA:    return SEL_DATA;
      PARITY:  return SEL_PAR;
      default: return SEL_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Byte handshake plus per-bit mux controls between the upstream source,
// the frame controller and the TX output mux.
interface uart_tx_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] P_DATA_CTRL;
  logic                  Data_Valid_CTRL;
  logic                  PAR_EN_CTRL;
  logic                  PAR_TYP_CTRL;
  logic [1:0]            mux_sel_CTRL;
  logic                  ser_data_CTRL;
  logic                  par_bit_CTRL;
  logic                  busy_CTRL;

  modport master (
    output P_DATA_CTRL, Data_Valid_CTRL, PAR_EN_CTRL, PAR_TYP_CTRL,
    input  mux_sel_CTRL, ser_data_CTRL, par_bit_CTRL, busy_CTRL
  );

  modport slave (
    input  P_DATA_CTRL, Data_Valid_CTRL, PAR_EN_CTRL, PAR_TYP_CTRL,
    output mux_sel_CTRL, ser_data_CTRL, par_bit_CTRL, busy_CTRL
  );
endinterface

// File: rtl/uart_parity_calc.sv
// Combinational parity of one data word; par_typ=0 gives even, 1 gives odd.
module uart_parity_calc #(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);
  assign par_bit = (^data) ^ par_typ;
endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: latches a byte, then walks start / data
// (LSB first) / optional parity / stop, one frame bit per clock.
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic           CLK_CTRL,
  input logic           RST_CTRL,
  uart_tx_ctrl_if.slave bus
);
  localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  tx_state_e             state;
  logic [CNT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_calc;
  logic                  accept;

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
    .data    (bus.P_DATA_CTRL),
    .par_typ (bus.PAR_TYP_CTRL),
    .par_bit (par_calc)
  );

  // STOP also accepts so back-to-back frames need no idle cycle.
  assign accept = bus.Data_Valid_CTRL && (state == IDLE || state == STOP);

  // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_CTRL) begin
    if (RST_CTRL) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state     <= START;
            shift_reg <= bus.P_DATA_CTRL;
            par_en_q  <= bus.PAR_EN_CTRL;
            par_bit_q <= par_calc;
          end else begin
            state <= IDLE;
          end
        end
        START: state <= DATA;
        DATA: begin
          shift_reg <= shift_reg >> 1;
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            state   <= par_en_q ? PARITY : STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY:  state <= STOP;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore outputs: decoded from the state register and datapath registers only.
  assign bus.mux_sel_CTRL  = sel_of(state);
  assign bus.busy_CTRL     = (state != IDLE);
  assign bus.ser_data_CTRL = shift_reg[0];
  assign bus.par_bit_CTRL  = par_bit_q;

endmodule
